// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mips_multicycle_ctrl
// Description : Multi-cycle sequencer for the MIPS datapath. Steps each
//               instruction through FETCH / DECODE / MEM / ADDM / WB, shares
//               one memory port with a ready handshake, converts memory
//               stalls longer than TIMEOUT cycles into a bus error, routes
//               decoder exceptions to EXC and counts retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             mem_ready,
  input  logic [1:0]       control_type,
  input  logic             writeenable,
  input  logic             mem_read,
  input  logic             word_we,
  input  logic             byte_we,
  input  logic             addm,
  input  logic             except,
  output logic             mem_req,
  output logic             mem_fetch,
  output logic             mem_rd,
  output logic             mem_word_we,
  output logic             mem_byte_we,
  output logic             ir_we,
  output logic             rf_we,
  output logic             addm_phase,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             pc_exc,
  output logic             exc_flag,
  output logic             bus_err,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state
);

  // Timer only needs to reach TIMEOUT-1, the last permitted waiting cycle.
  localparam int               TMR_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_MEM    = 3'd2,
    ST_ADDM   = 3'd3,
    ST_WB     = 3'd4,
    ST_EXC    = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  // State, wait timer and retire counter; asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_FETCH;
      timer_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retired_q <= retired_d;
    end
  end

  // Next-state and output decode. The timer defaults to zero, so it is
  // cleared on every state change and only counts while a request stalls.
  always_comb begin
    state_d     = state_q;
    timer_d     = '0;
    retired_d   = retired_q;
    mem_req     = 1'b0;
    mem_fetch   = 1'b0;
    mem_rd      = 1'b0;
    mem_word_we = 1'b0;
    mem_byte_we = 1'b0;
    ir_we       = 1'b0;
    rf_we       = 1'b0;
    addm_phase  = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = 2'd0;
    pc_exc      = 1'b0;
    exc_flag    = 1'b0;
    bus_err     = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (run) begin
          mem_req   = 1'b1;
          mem_fetch = 1'b1;
          mem_rd    = 1'b1;
          if (mem_ready) begin
            // Ready wins over an expiring timer.
            ir_we   = 1'b1;
            state_d = ST_DECODE;
          end else if (timer_q == TMR_LAST) begin
            bus_err = 1'b1;
            state_d = ST_EXC;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end

      ST_DECODE: begin
        if (except) begin
          state_d = ST_EXC;
        end else if (mem_read || word_we || byte_we || addm) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end

      ST_MEM: begin
        mem_req     = 1'b1;
        mem_rd      = mem_read | addm;
        mem_word_we = word_we;
        mem_byte_we = byte_we;
        if (mem_ready) begin
          state_d = addm ? ST_ADDM : ST_WB;
        end else if (timer_q == TMR_LAST) begin
          bus_err = 1'b1;
          state_d = ST_EXC;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ST_ADDM: begin
        addm_phase = 1'b1;
        state_d    = ST_WB;
      end

      ST_WB: begin
        rf_we     = writeenable;
        pc_we     = 1'b1;
        pc_sel    = control_type;
        retired_d = retired_q + 1'b1;
        state_d   = ST_FETCH;
      end

      ST_EXC: begin
        exc_flag = 1'b1;
        pc_we    = 1'b1;
        pc_exc   = 1'b1;
        state_d  = ST_FETCH;
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase

    // Keep every strobe quiet while reset is held, even with run=1.
    if (!reset) begin
      mem_req     = 1'b0;
      mem_fetch   = 1'b0;
      mem_rd      = 1'b0;
      mem_word_we = 1'b0;
      mem_byte_we = 1'b0;
      ir_we       = 1'b0;
      rf_we       = 1'b0;
      addm_phase  = 1'b0;
      pc_we       = 1'b0;
      pc_sel      = 2'd0;
      pc_exc      = 1'b0;
      exc_flag    = 1'b0;
      bus_err     = 1'b0;
    end
  end

  assign retired = retired_q;
  assign state   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_multicycle_ctrl
// Description : Scoreboard bench for mips_multicycle_ctrl. The stimulus
//               process drives one cycle at a time and queues the expected
//               state/strobes/retired for that cycle; a monitor pops and
//               compares on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_ctrl;

  // Expected strobe vector layout, MSB first.
  localparam logic [13:0] B_REQ   = 14'h2000;
  localparam logic [13:0] B_FET   = 14'h1000;
  localparam logic [13:0] B_RD    = 14'h0800;
  localparam logic [13:0] B_WW    = 14'h0400;
  localparam logic [13:0] B_WB    = 14'h0200;
  localparam logic [13:0] B_IR    = 14'h0100;
  localparam logic [13:0] B_RF    = 14'h0080;
  localparam logic [13:0] B_AP    = 14'h0040;
  localparam logic [13:0] B_PCWE  = 14'h0020;
  localparam logic [13:0] B_SEL1  = 14'h0008;
  localparam logic [13:0] B_SEL3  = 14'h0018;
  localparam logic [13:0] B_PCEXC = 14'h0004;
  localparam logic [13:0] B_EXC   = 14'h0002;
  localparam logic [13:0] B_BUS   = 14'h0001;
  localparam logic [13:0] F_WAIT  = B_REQ | B_FET | B_RD;
  localparam logic [13:0] F_HIT   = B_REQ | B_FET | B_RD | B_IR;
  localparam logic [13:0] E_EXC   = B_EXC | B_PCWE | B_PCEXC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        mem_ready = 1'b0;
  logic [1:0]  control_type = 2'd0;
  logic        writeenable = 1'b0;
  logic        mem_read = 1'b0;
  logic        word_we = 1'b0;
  logic        byte_we = 1'b0;
  logic        addm = 1'b0;
  logic        except = 1'b0;

  logic        mem_req, mem_fetch, mem_rd, mem_word_we, mem_byte_we;
  logic        ir_we, rf_we, addm_phase, pc_we, pc_exc, exc_flag, bus_err;
  logic [1:0]  pc_sel;
  logic [31:0] retired;
  logic [2:0]  state;

  logic [48:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;

  mips_multicycle_ctrl #(.CNT_W(32), .TIMEOUT(16)) dut (
    .clock       (clk),
    .reset       (rst_n),
    .run         (run),
    .mem_ready   (mem_ready),
    .control_type(control_type),
    .writeenable (writeenable),
    .mem_read    (mem_read),
    .word_we     (word_we),
    .byte_we     (byte_we),
    .addm        (addm),
    .except      (except),
    .mem_req     (mem_req),
    .mem_fetch   (mem_fetch),
    .mem_rd      (mem_rd),
    .mem_word_we (mem_word_we),
    .mem_byte_we (mem_byte_we),
    .ir_we       (ir_we),
    .rf_we       (rf_we),
    .addm_phase  (addm_phase),
    .pc_we       (pc_we),
    .pc_sel      (pc_sel),
    .pc_exc      (pc_exc),
    .exc_flag    (exc_flag),
    .bus_err     (bus_err),
    .retired     (retired),
    .state       (state)
  );

  always #5 clk = ~clk;

  // Monitor: compare the DUT against the queued expectation each falling edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [48:0] e;
      logic [48:0] a;
      string       nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {state, mem_req, mem_fetch, mem_rd, mem_word_we, mem_byte_we,
            ir_we, rf_we, addm_phase, pc_we, pc_sel, pc_exc, exc_flag,
            bus_err, retired};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got state=%0d ctl=%h retired=%0d, expected state=%0d ctl=%h retired=%0d",
                 nm, a[48:46], a[45:32], a[31:0], e[48:46], e[45:32], e[31:0]);
      end
    end
  end

  // One cycle of stimulus plus its expected response.
  task automatic cyc(input logic rn, input logic rr, input logic rdy,
                     input logic [2:0] est, input logic [13:0] ectl,
                     input logic [31:0] eret, input string nm);
    @(posedge clk);
    #1;
    rst_n     = rn;
    run       = rr;
    mem_ready = rdy;
    exp_q.push_back({est, ectl, eret});
    name_q.push_back(nm);
  endtask

  // Decoder outputs for the next instruction; only called during idle FETCH.
  task automatic dec(input logic [1:0] ct, input logic we, input logic mr,
                     input logic ww, input logic bw, input logic am,
                     input logic ex);
    control_type = ct;
    writeenable  = we;
    mem_read     = mr;
    word_we      = ww;
    byte_we      = bw;
    addm         = am;
    except       = ex;
  endtask

  initial begin
    // Reset held with run/ready high: strobes must stay quiet.
    cyc(0, 1, 1, 3'd0, 14'h0, 0, "reset_gated");

    // add: 0,1,4
    dec(2'd0, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 3'd0, F_HIT, 0, "add_fetch");
    cyc(1, 1, 0, 3'd1, 14'h0, 0, "add_decode");
    cyc(1, 1, 0, 3'd4, B_RF | B_PCWE, 0, "add_wb");
    cyc(1, 0, 0, 3'd0, 14'h0, 1, "add_idle");

    // lw with three wait cycles in MEM
    dec(2'd0, 1, 1, 0, 0, 0, 0);
    cyc(1, 1, 1, 3'd0, F_HIT, 1, "lw_fetch");
    cyc(1, 1, 0, 3'd1, 14'h0, 1, "lw_decode");
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 3'd2, B_REQ | B_RD, 1, "lw_mem_wait");
    cyc(1, 1, 1, 3'd2, B_REQ | B_RD, 1, "lw_mem_ready");
    cyc(1, 1, 0, 3'd4, B_RF | B_PCWE, 1, "lw_wb");
    cyc(1, 0, 0, 3'd0, 14'h0, 2, "lw_idle");

    // addm: 0,1,2,3,4
    dec(2'd0, 1, 0, 0, 0, 1, 0);
    cyc(1, 1, 1, 3'd0, F_HIT, 2, "addm_fetch");
    cyc(1, 1, 0, 3'd1, 14'h0, 2, "addm_decode");
    cyc(1, 1, 1, 3'd2, B_REQ | B_RD, 2, "addm_mem");
    cyc(1, 1, 0, 3'd3, B_AP, 2, "addm_phase");
    cyc(1, 1, 0, 3'd4, B_RF | B_PCWE, 2, "addm_wb");
    cyc(1, 0, 0, 3'd0, 14'h0, 3, "addm_idle");

    // sb: byte strobe in MEM, no register write
    dec(2'd0, 0, 0, 0, 1, 0, 0);
    cyc(1, 1, 1, 3'd0, F_HIT, 3, "sb_fetch");
    cyc(1, 1, 0, 3'd1, 14'h0, 3, "sb_decode");
    cyc(1, 1, 1, 3'd2, B_REQ | B_WB, 3, "sb_mem");
    cyc(1, 1, 0, 3'd4, B_PCWE, 3, "sb_wb");
    cyc(1, 0, 0, 3'd0, 14'h0, 4, "sb_idle");

    // sw: word strobe in MEM
    dec(2'd0, 0, 0, 1, 0, 0, 0);
    cyc(1, 1, 1, 3'd0, F_HIT, 4, "sw_fetch");
    cyc(1, 1, 0, 3'd1, 14'h0, 4, "sw_decode");
    cyc(1, 1, 1, 3'd2, B_REQ | B_WW, 4, "sw_mem");
    cyc(1, 1, 0, 3'd4, B_PCWE, 4, "sw_wb");
    cyc(1, 0, 0, 3'd0, 14'h0, 5, "sw_idle");

    // taken branch: pc_sel=1
    dec(2'd1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 3'd0, F_HIT, 5, "beq_fetch");
    cyc(1, 1, 0, 3'd1, 14'h0, 5, "beq_decode");
    cyc(1, 1, 0, 3'd4, B_PCWE | B_SEL1, 5, "beq_wb");
    cyc(1, 0, 0, 3'd0, 14'h0, 6, "beq_idle");

    // jr: pc_sel=3
    dec(2'd3, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 3'd0, F_HIT, 6, "jr_fetch");
    cyc(1, 1, 0, 3'd1, 14'h0, 6, "jr_decode");
    cyc(1, 1, 0, 3'd4, B_PCWE | B_SEL3, 6, "jr_wb");
    cyc(1, 0, 0, 3'd0, 14'h0, 7, "jr_idle");

    // lwc3: except overrides the load, retired unchanged
    dec(2'd0, 1, 1, 0, 0, 0, 1);
    cyc(1, 1, 1, 3'd0, F_HIT, 7, "exc_fetch");
    cyc(1, 1, 0, 3'd1, 14'h0, 7, "exc_decode");
    cyc(1, 1, 0, 3'd5, E_EXC, 7, "exc_step");
    cyc(1, 0, 0, 3'd0, 14'h0, 7, "exc_idle");

    // Fetch timeout: bus_err in the 16th request cycle, then EXC
    dec(2'd0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) cyc(1, 1, 0, 3'd0, F_WAIT, 7, "fetch_wait");
    cyc(1, 1, 0, 3'd0, F_WAIT | B_BUS, 7, "fetch_timeout");
    cyc(1, 0, 0, 3'd5, E_EXC, 7, "fetch_timeout_exc");
    cyc(1, 0, 0, 3'd0, 14'h0, 7, "fetch_timeout_idle");

    // Ready arriving exactly in the expiry cycle wins
    for (int i = 0; i < 15; i++) cyc(1, 1, 0, 3'd0, F_WAIT, 7, "fetch_wait2");
    cyc(1, 1, 1, 3'd0, F_HIT, 7, "fetch_ready_at_expiry");
    cyc(1, 1, 0, 3'd1, 14'h0, 7, "late_decode");
    cyc(1, 1, 0, 3'd4, B_RF | B_PCWE, 7, "late_wb");
    cyc(1, 0, 0, 3'd0, 14'h0, 8, "late_idle");

    // MEM timeout: no rf_we, goes to EXC, retired unchanged
    dec(2'd0, 1, 1, 0, 0, 0, 0);
    cyc(1, 1, 1, 3'd0, F_HIT, 8, "memto_fetch");
    cyc(1, 1, 0, 3'd1, 14'h0, 8, "memto_decode");
    for (int i = 0; i < 15; i++) cyc(1, 1, 0, 3'd2, B_REQ | B_RD, 8, "memto_wait");
    cyc(1, 1, 0, 3'd2, B_REQ | B_RD | B_BUS, 8, "mem_timeout");
    cyc(1, 1, 0, 3'd5, E_EXC, 8, "mem_timeout_exc");
    cyc(1, 0, 0, 3'd0, 14'h0, 8, "memto_idle");

    // Asynchronous reset in the middle of MEM, then run=0 keeps mem_req low
    cyc(1, 1, 1, 3'd0, F_HIT, 8, "rst_fetch");
    cyc(1, 1, 0, 3'd1, 14'h0, 8, "rst_decode");
    cyc(1, 1, 0, 3'd2, B_REQ | B_RD, 8, "rst_mem");
    cyc(0, 1, 0, 3'd0, 14'h0, 0, "async_reset_mid_mem");
    for (int i = 0; i < 5; i++) cyc(1, 0, 1, 3'd0, 14'h0, 0, "run0_idle");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multi-cycle sequencer that drives the MIPS datapath from the outputs of the combinational instruction decoder (mips_decode). It steps each instruction through fetch, decode, memory, addm-execute and writeback over several cycles, and shares one memory port with a ready handshake. It enforces a memory timeout, routes decoder exceptions and bus errors to an exception step, and counts retired instructions.

Parameters:
CNT_W, 32, width of the retired-instruction counter
TIMEOUT, 16, maximum number of cycles to wait for mem_ready before a bus error (must be ≥2)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
run  in  1  permits a new fetch; sampled only in FETCH
mem_ready  in  1  memory completes the current request this cycle
control_type  in  2  from decoder: 0=sequential, 1=branch taken, 2=jump, 3=jr
writeenable  in  1  from decoder: register-file write
mem_read  in  1  from decoder: load
word_we  in  1  from decoder: word store
byte_we  in  1  from decoder: byte store
addm  in  1  from decoder: addm instruction
except  in  1  from decoder: unrecognised instruction
mem_req  out  1  memory request valid
mem_fetch  out  1  request is an instruction fetch (address comes from the PC)
mem_rd  out  1  request is a read
mem_word_we  out  1  word write strobe
mem_byte_we  out  1  byte write strobe
ir_we  out  1  latch the instruction register
rf_we  out  1  register-file write
addm_phase  out  1  ALU adds the memory data (addm second operand)
pc_we  out  1  PC update
pc_sel  out  2  next-PC select; equals control_type during writeback
pc_exc  out  1  PC loads the exception vector
exc_flag  out  1  one-cycle exception pulse
bus_err  out  1  one-cycle memory-timeout pulse
retired  out  CNT_W  count of retired instructions
state  out  3  current state (debug)

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEM=2, ADDM=3, WB=4, EXC=5. Codes 6 and 7 go to FETCH on the next clock.
- All outputs are Moore outputs decoded from state, except where this section says otherwise. Outputs not listed for a state are 0.
- Reset (reset=0, asynchronous, including mid-instruction):
  - State goes to FETCH.
  - retired=0 and the wait timer=0.
  - All strobes and pulses are 0 while reset is held.
- FETCH:
  - If run=0: mem_req=0, timer held at 0, stay in FETCH.
  - If run=1: mem_req=1, mem_fetch=1, mem_rd=1.
  - When mem_ready=1: ir_we=1 in the same cycle (Mealy), next state DECODE.
- DECODE (exactly one cycle):
  - except=1 → EXC.
  - Otherwise, if mem_read|word_we|byte_we|addm → MEM.
  - Otherwise → WB.
  - except has priority over every other decoder input.
- MEM:
  - mem_req=1, mem_rd=mem_read|addm, mem_word_we=word_we, mem_byte_we=byte_we.
  - Stay until mem_ready=1. Then go to ADDM if addm=1, else to WB.
- ADDM: addm_phase=1 for one cycle, then WB.
- WB (one cycle):
  - rf_we=writeenable. Decoder guarantees writeenable=0 for stores and branches.
  - pc_we=1, pc_sel=control_type.
  - retired increments by 1, wrapping modulo 2^CNT_W.
  - Next state FETCH.
- EXC (one cycle):
  - exc_flag=1, pc_we=1, pc_exc=1, pc_sel=0.
  - retired is unchanged. Next state FETCH.
- Memory timeout:
  - The timer clears on entry to FETCH (with run=1) or to MEM, and increments on each cycle with mem_req=1 and mem_ready=0.
  - If the timer reaches TIMEOUT-1 and mem_ready=0 in that cycle: bus_err=1 (Mealy, one cycle), next state EXC. ir_we and rf_we are not asserted.
  - If mem_ready=1 in the expiry cycle, ready wins and there is no bus_err.
- Decoder inputs are assumed stable from DECODE through WB, because the IR is held. The controller does not register them.
- Latency: 1 cycle per state with zero-wait memory.
  - ALU and branch instructions: 3 cycles (FETCH, DECODE, WB).
  - Load and store: 4 cycles.
  - addm: 5 cycles.

Test Plan:
- Reset, run=1, zero-wait memory, add (control_type=0, writeenable=1) → state sequence 0,1,4,0. ir_we in cycle 1, rf_we=1 and pc_we=1 with pc_sel=0 in cycle 3. retired=1.
- lw with mem_ready delayed 3 cycles in MEM → MEM held 4 cycles with mem_rd=1. Then WB with rf_we=1. Total 7 cycles. retired=1.
- addm → states 0,1,2,3,4. addm_phase=1 only in ADDM. sb → MEM with mem_byte_we=1, then WB with rf_we=0.
- except=1 (lwc3) → DECODE→EXC. exc_flag=1, pc_exc=1 for one cycle. retired unchanged. Next state FETCH.
- TIMEOUT=16, mem_ready held 0 in FETCH → bus_err pulses in the 16th request cycle, then EXC. With mem_ready=1 arriving exactly in that cycle → no bus_err, ir_we=1.
- Drive reset low in the middle of MEM → state=0 and retired=0 immediately (asynchronous). run=0 after reset → mem_req stays 0 indefinitely.
